// File: rtl/io_bridge_pkg.sv
// Shared address map, read-source encoding and stop-FSM states for the CPU-side IO bridge.
package io_bridge_pkg;

    localparam logic [17:0] IO_BASE = 18'h30000;
    localparam logic [17:0] IO_UART = 18'h30000;
    localparam logic [17:0] IO_CLK  = 18'h30004;

    typedef enum logic [1:0] {
        SrcRam,
        SrcRx,
        SrcCnt,
        SrcZero
    } rd_src_e;

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StStopped
    } stop_state_e;

    // Little-endian byte lane of the cycle counter.
    function automatic logic [7:0] cnt_byte(input logic [31:0] cnt, input logic [1:0] sel);
        logic [7:0] b;
        unique case (sel)
            2'd0:    b = cnt[7:0];
            2'd1:    b = cnt[15:8];
            2'd2:    b = cnt[23:16];
            default: b = cnt[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/io_bridge_fifo.sv
// Byte-wide synchronous FIFO used as the UART TX queue; accepts a push when full if a pop
// happens in the same cycle.
module byte_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic [7:0]                   data_i,
    input  logic                         pop_i,
    output logic [7:0]                   data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_next_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic                         drop_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_acc, pop_acc;

    assign empty_o  = (count_q == '0);
    assign full_o   = (count_q == CW'(DEPTH));
    assign pop_acc  = pop_i & ~empty_o;
    assign push_acc = push_i & (~full_o | pop_acc);
    assign drop_o   = push_i & ~push_acc;
    assign data_o   = mem_q[rd_ptr_q];
    assign count_o  = count_q;
    assign count_next_o = count_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop_acc) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (push_acc && !pop_acc) begin
            count_d = count_q + CW'(1);
        end else if (!push_acc && pop_acc) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; emptiness is tracked by count_q alone.
    always_ff @(posedge clk_i) begin
        if (push_acc) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/io_bridge.sv
// CPU bus bridge: decodes RAM vs memory-mapped UART/cycle-counter, queues TX bytes and
// tracks program termination.
module io_bridge
    import io_bridge_pkg::*;
#(
    parameter int unsigned TX_DEPTH = 8,
    parameter int unsigned RAM_AW   = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [31:0]       cpu_a,
    input  logic              cpu_wr,
    input  logic [7:0]        cpu_dout,
    output logic [7:0]        cpu_din,
    output logic              io_buffer_full,
    output logic [RAM_AW-1:0] ram_a,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_pop,
    output logic              prog_stop,
    output logic              tx_overflow
);

    localparam int unsigned CW = $clog2(TX_DEPTH + 1);

    logic          io_sel, uart_hit, clk_hit, cnt_hit;
    logic          wr_req, rd_req;
    logic          push;
    logic [7:0]    push_data;
    logic [CW-1:0] fifo_count, fifo_count_next;
    logic          fifo_full, fifo_empty, fifo_drop;

    logic          rd_valid_q, rd_valid_d;
    rd_src_e       rd_src_q, rd_src_d;
    logic [7:0]    rd_byte_q, rd_byte_d;
    logic [7:0]    dout_q, dout_d;
    logic [31:0]   cnt_q, cnt_d;
    stop_state_e   state_q, state_d;
    logic          ovf_q, ovf_d;
    logic          buf_full_q, buf_full_d;

    logic          unused_bits;
    assign unused_bits = ^{cpu_a[31:18], fifo_count, fifo_full};

    assign io_sel   = (cpu_a[17:16] == IO_BASE[17:16]);
    assign uart_hit = (cpu_a[17:0] == IO_UART);
    assign clk_hit  = (cpu_a[17:0] == IO_CLK);
    assign cnt_hit  = (cpu_a[17:2] == IO_CLK[17:2]);
    assign wr_req   = rdy & cpu_wr;
    assign rd_req   = rdy & ~cpu_wr;

    assign ram_a    = cpu_a[RAM_AW-1:0];
    assign ram_dout = cpu_dout;
    assign ram_wr   = wr_req & ~io_sel;

    // The stop register pushes a 0x00 terminator behind any queued output.
    assign push      = wr_req & ((uart_hit & (cpu_dout != 8'h00)) | clk_hit);
    assign push_data = clk_hit ? 8'h00 : cpu_dout;
    assign rx_pop    = rd_req & uart_hit & rx_valid;

    byte_fifo #(
        .DEPTH(TX_DEPTH)
    ) u_tx_fifo (
        .clk_i       (clk),
        .rst_ni      (rst),
        .push_i      (push),
        .data_i      (push_data),
        .pop_i       (tx_ready),
        .data_o      (tx_data),
        .count_o     (fifo_count),
        .count_next_o(fifo_count_next),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .drop_o      (fifo_drop)
    );

    assign tx_valid       = ~fifo_empty;
    assign io_buffer_full = buf_full_q;
    assign tx_overflow    = ovf_q;
    assign prog_stop      = (state_q == StStopped);

    // Read launch: source and byte are captured in the request cycle.
    always_comb begin
        rd_valid_d = rd_req;
        rd_src_d   = SrcZero;
        rd_byte_d  = 8'h00;
        if (!io_sel) begin
            rd_src_d = SrcRam;
        end else if (uart_hit && rx_valid) begin
            rd_src_d  = SrcRx;
            rd_byte_d = rx_data;
        end else if (cnt_hit) begin
            rd_src_d  = SrcCnt;
            rd_byte_d = cnt_byte(cnt_q, cpu_a[1:0]);
        end
    end

    always_comb begin
        cpu_din = dout_q;
        if (rd_valid_q) begin
            cpu_din = (rd_src_q == SrcRam) ? ram_din : rd_byte_q;
        end
        dout_d = cpu_din;
    end

    always_comb begin
        cnt_d      = cnt_q + 32'd1;
        ovf_d      = ovf_q | fifo_drop;
        buf_full_d = (fifo_count_next >= CW'(TX_DEPTH - 1));
        state_d    = state_q;
        unique case (state_q)
            StRun:     if (wr_req && clk_hit) state_d = StDrain;
            StDrain:   if (fifo_empty && !push) state_d = StStopped;
            StStopped: state_d = StStopped;
            default:   state_d = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_valid_q <= 1'b0;
            rd_src_q   <= SrcZero;
            rd_byte_q  <= 8'h00;
            dout_q     <= 8'h00;
            cnt_q      <= 32'd0;
            state_q    <= StRun;
            ovf_q      <= 1'b0;
            buf_full_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_src_q   <= rd_src_d;
            rd_byte_q  <= rd_byte_d;
            dout_q     <= dout_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            ovf_q      <= ovf_d;
            buf_full_q <= buf_full_d;
        end
    end

endmodule
